// File: rtl/mem_fill_arbiter.sv
// Write-port arbiter shared by CPU stores and a constant-fill engine (screen clear / memset).
// CPU writes always own the port; the fill engine consumes every cycle the CPU leaves idle.
module mem_fill_arbiter #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpu_write_m,
  input  logic [ADDR_WIDTH-1:0] cpu_write_addr,
  input  logic [DATA_WIDTH-1:0] cpu_out_m,
  input  logic                  fill_req,
  input  logic [ADDR_WIDTH-1:0] fill_base,
  input  logic [ADDR_WIDTH:0]   fill_len,
  input  logic [DATA_WIDTH-1:0] fill_value,
  input  logic                  fill_abort,
  output logic                  ram_wren,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_data,
  output logic                  fill_busy,
  output logic                  fill_done,
  output logic [15:0]           fill_stalls
);

  typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

  state_t                state;
  state_t                state_next;
  logic [ADDR_WIDTH-1:0] ptr;
  logic [ADDR_WIDTH:0]   remaining;
  logic [DATA_WIDTH-1:0] fill_val;
  logic                  fill_write;
  logic                  fill_stolen;

  // An abort suppresses the fill write in the same cycle it is seen.
  assign fill_write  = (state == FILL) && !fill_abort && !cpu_write_m;
  assign fill_stolen = (state == FILL) && !fill_abort && cpu_write_m;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (fill_req) state_next = (fill_len == '0) ? DONE : FILL;
      FILL: begin
        if (fill_abort)                                     state_next = IDLE;
        else if (fill_write && remaining == (ADDR_WIDTH+1)'(1)) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr         <= '0;
      remaining   <= '0;
      fill_val    <= '0;
      fill_stalls <= '0;
    end else begin
      if (state == IDLE && fill_req) begin
        ptr         <= fill_base;
        remaining   <= fill_len;
        fill_val    <= fill_value;
        fill_stalls <= '0;
      end
      if (fill_stolen && fill_stalls != 16'hFFFF) fill_stalls <= fill_stalls + 16'd1;
      // ptr wraps naturally at 2^ADDR_WIDTH.
      if (fill_write) begin
        ptr       <= ptr + ADDR_WIDTH'(1);
        remaining <= remaining - (ADDR_WIDTH+1)'(1);
      end
    end
  end

  always_comb begin
    ram_wren = 1'b0;
    ram_addr = ptr;
    ram_data = fill_val;
    if (cpu_write_m) begin
      ram_wren = 1'b1;
      ram_addr = cpu_write_addr;
      ram_data = cpu_out_m;
    end else if (fill_write) begin
      ram_wren = 1'b1;
    end
  end

  assign fill_busy = (state != IDLE);
  assign fill_done = (state == DONE);

endmodule

// File: tb/tb_mem_fill_arbiter.sv
// Bench for mem_fill_arbiter: expected port writes are queued as stimulus is driven and
// popped by a negedge monitor; per-scenario tasks check done timing, counts and stalls.
module tb_mem_fill_arbiter;
  localparam int AW = 10;
  localparam int DW = 16;

  logic          clk;
  logic          rst;
  logic          cpu_write_m;
  logic [AW-1:0] cpu_write_addr;
  logic [DW-1:0] cpu_out_m;
  logic          fill_req;
  logic [AW-1:0] fill_base;
  logic [AW:0]   fill_len;
  logic [DW-1:0] fill_value;
  logic          fill_abort;
  logic          ram_wren;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_data;
  logic          fill_busy;
  logic          fill_done;
  logic [15:0]   fill_stalls;

  mem_fill_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst),
    .cpu_write_m(cpu_write_m), .cpu_write_addr(cpu_write_addr), .cpu_out_m(cpu_out_m),
    .fill_req(fill_req), .fill_base(fill_base), .fill_len(fill_len),
    .fill_value(fill_value), .fill_abort(fill_abort),
    .ram_wren(ram_wren), .ram_addr(ram_addr), .ram_data(ram_data),
    .fill_busy(fill_busy), .fill_done(fill_done), .fill_stalls(fill_stalls)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  // scoreboard: {addr, data} of every expected port write, in order
  logic [AW+DW-1:0] exp_q[$];
  logic [DW-1:0]    tb_mem[1024];
  int               hit[1024];
  int               wr_cnt;
  int               busy_cnt;
  int               done_cnt;
  int               done_cyc;

  always @(negedge clk) begin
    if (!rst) begin
      if (ram_wren) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL port_write: unexpected write addr=%h data=%h at cycle %0d, none required",
                   ram_addr, ram_data, cyc);
        end else begin
          logic [AW+DW-1:0] exp_w;
          exp_w = exp_q.pop_front();
          if ({ram_addr, ram_data} !== exp_w) begin
            n_fail++;
            $display("FAIL port_write: cycle %0d got addr=%h data=%h, required addr=%h data=%h",
                     cyc, ram_addr, ram_data, exp_w[AW+DW-1:DW], exp_w[DW-1:0]);
          end
        end
        if (!cpu_write_m) begin
          wr_cnt++;
          hit[ram_addr]++;
        end
        tb_mem[ram_addr] = ram_data;
      end
      if (fill_busy) busy_cnt++;
      if (fill_done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  // One fill transaction: fill_req in cycle 0, optional CPU writes (cpu_mask bit k = cycle k),
  // abort / second request / reset at the given cycles (-1 = never). Runs cycles 0..n_cyc-1.
  task automatic run_fill(input string name, input logic [AW-1:0] base, input logic [AW:0] len,
                          input logic [DW-1:0] value, input logic [63:0] cpu_mask,
                          input logic [AW-1:0] c_addr, input logic [DW-1:0] c_data,
                          input int abort_cyc, input int req_cyc, input int rst_cyc,
                          input int n_cyc, input int exp_done, input int exp_busy,
                          input int exp_wr, input int exp_stalls);
    logic          m_active;
    int            m_rem;
    logic [AW-1:0] m_ptr;
    m_active = 1'b0;
    m_rem    = 0;
    m_ptr    = base;
    wr_cnt   = 0;
    busy_cnt = 0;
    done_cnt = 0;
    done_cyc = -1;
    for (int i = 0; i < 1024; i++) hit[i] = 0;
    for (int k = 0; k < n_cyc; k++) begin
      @(posedge clk);
      #1;
      cyc            = k;
      fill_req       = (k == 0) || (k == req_cyc);
      fill_base      = (k == req_cyc) ? 10'h300 : base;
      fill_len       = (k == req_cyc) ? 11'd3 : len;
      fill_value     = (k == req_cyc) ? 16'h5555 : value;
      fill_abort     = (k == abort_cyc);
      cpu_write_m    = (k < 64) ? cpu_mask[k] : 1'b0;
      cpu_write_addr = c_addr;
      cpu_out_m      = c_data;
      if (cpu_write_m) begin
        exp_q.push_back({c_addr, c_data});
      end else if (m_active && k != abort_cyc && k != rst_cyc) begin
        exp_q.push_back({m_ptr, value});
        m_ptr = m_ptr + 10'd1;
        m_rem--;
      end
      if (k == abort_cyc || k == rst_cyc || m_rem == 0) m_active = 1'b0;
      if (k == 0) begin
        m_active = (len != 0);
        m_rem    = int'(len);
      end
      rst = (k == rst_cyc);
      if (k == rst_cyc) begin
        #1;
        n_cmp++;
        if ({ram_wren, fill_busy, fill_done, fill_stalls} !== 19'd0) begin
          n_fail++;
          $display("FAIL %s_reset_now: got wren=%b busy=%b done=%b stalls=%0d, required all 0",
                   name, ram_wren, fill_busy, fill_done, fill_stalls);
        end
      end
    end
    @(negedge clk);
    #1;
    fill_req    = 1'b0;
    fill_abort  = 1'b0;
    cpu_write_m = 1'b0;
    rst         = 1'b0;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_missing: got %0d writes still pending, required 0", name, exp_q.size());
      exp_q.delete();
    end
    n_cmp++;
    if (wr_cnt != exp_wr) begin
      n_fail++;
      $display("FAIL %s_fill_writes: got %0d, required %0d", name, wr_cnt, exp_wr);
    end
    n_cmp++;
    if (fill_stalls !== 16'(exp_stalls)) begin
      n_fail++;
      $display("FAIL %s_stalls: got %0d, required %0d", name, fill_stalls, exp_stalls);
    end
    n_cmp++;
    if (exp_done < 0 ? (done_cnt != 0) : (done_cnt != 1 || done_cyc != exp_done)) begin
      n_fail++;
      $display("FAIL %s_done: got %0d pulses last at cycle %0d, required pulse cycle %0d",
               name, done_cnt, done_cyc, exp_done);
    end
    n_cmp++;
    if (busy_cnt != exp_busy) begin
      n_fail++;
      $display("FAIL %s_busy: got %0d cycles, required %0d", name, busy_cnt, exp_busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cpu_write_m = 1'b0; cpu_write_addr = '0; cpu_out_m = '0;
    fill_req = 1'b0; fill_base = '0; fill_len = '0; fill_value = '0; fill_abort = 1'b0;
    for (int i = 0; i < 1024; i++) tb_mem[i] = 16'hA5A5;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({ram_wren, fill_busy, fill_done} !== 3'b000 || fill_stalls !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_flags: got wren=%b busy=%b done=%b stalls=%0d, required 0 0 0 0",
               ram_wren, fill_busy, fill_done, fill_stalls);
    end
    n_cmp++;
    if (ram_addr !== 10'd0 || ram_data !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_port: got addr=%h data=%h, required 000 0000", ram_addr, ram_data);
    end
    rst = 1'b0;
  endtask

  task automatic test_cpu_passthrough();
    for (int k = 0; k < 16; k++) begin
      @(posedge clk);
      #1;
      cpu_write_m    = 1'($urandom_range(0, 1));
      cpu_write_addr = 10'($urandom_range(0, 1023));
      cpu_out_m      = 16'($urandom_range(0, 65535));
      if (cpu_write_m) exp_q.push_back({cpu_write_addr, cpu_out_m});
    end
    @(negedge clk);
    #1;
    cpu_write_m = 1'b0;
    n_cmp++;
    if (exp_q.size() != 0 || fill_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL cpu_passthrough: got %0d pending busy=%b, required 0 pending busy=0",
               exp_q.size(), fill_busy);
      exp_q.delete();
    end
  endtask

  task automatic test_basic();
    run_fill("basic", 10'h010, 11'd4, 16'hBEEF, 64'd0, 10'h0, 16'h0, -1, -1, -1, 7, 5, 5, 4, 0);
    n_cmp++;
    if (tb_mem[16] !== 16'hBEEF || tb_mem[19] !== 16'hBEEF || tb_mem[20] !== 16'hA5A5) begin
      n_fail++;
      $display("FAIL basic_mem: got [010]=%h [013]=%h [014]=%h, required beef beef a5a5",
               tb_mem[16], tb_mem[19], tb_mem[20]);
    end
  endtask

  task automatic test_contention();
    run_fill("contend", 10'h000, 11'd8, 16'h0F0F, 64'h0C, 10'h3FF, 16'h1234,
             -1, -1, -1, 13, 11, 11, 8, 2);
    n_cmp++;
    if (tb_mem[1023] !== 16'h1234 || hit[7] != 1 || hit[8] != 0) begin
      n_fail++;
      $display("FAIL contend_mem: got [3ff]=%h hit7=%0d hit8=%0d, required 1234 1 0",
               tb_mem[1023], hit[7], hit[8]);
    end
  endtask

  task automatic test_wrap();
    run_fill("wrap", 10'h3FE, 11'd4, 16'h00FF, 64'd0, 10'h0, 16'h0, -1, -1, -1, 7, 5, 5, 4, 0);
  endtask

  task automatic test_zero_and_full();
    int bad;
    run_fill("zero", 10'h123, 11'd0, 16'h7777, 64'd0, 10'h0, 16'h0, -1, -1, -1, 3, 1, 1, 0, 0);
    run_fill("full", 10'h200, 11'd1024, 16'hC0DE, 64'd0, 10'h0, 16'h0,
             -1, -1, -1, 1027, 1025, 1025, 1024, 0);
    bad = 0;
    for (int i = 0; i < 1024; i++) if (hit[i] != 1) bad++;
    n_cmp++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL full_coverage: got %0d addresses not hit exactly once, required 0", bad);
    end
  endtask

  task automatic test_abort();
    run_fill("abort", 10'h040, 11'd16, 16'hABCD, 64'd0, 10'h0, 16'h0, 5, 3, -1, 8, -1, 5, 4, 0);
    n_cmp++;
    if (fill_busy !== 1'b0 || hit[68] != 0) begin
      n_fail++;
      $display("FAIL abort_idle: got busy=%b hit[044]=%0d, required 0 0", fill_busy, hit[68]);
    end
  endtask

  task automatic test_reset_mid_fill();
    run_fill("rstmid", 10'h080, 11'd10, 16'h1111, 64'd0, 10'h0, 16'h0, -1, -1, 3, 6, -1, 2, 2, 0);
    run_fill("after_rst", 10'h090, 11'd3, 16'h2222, 64'd0, 10'h0, 16'h0, -1, -1, -1, 6, 4, 4, 3, 0);
  endtask

  task automatic test_back_to_back();
    run_fill("b2b_a", 10'h100, 11'd2, 16'h3333, 64'd0, 10'h0, 16'h0, -1, -1, -1, 4, 3, 3, 2, 0);
    run_fill("b2b_b", 10'h110, 11'd2, 16'h4444, 64'h02, 10'h001, 16'h9999,
             -1, -1, -1, 6, 4, 4, 2, 1);
  endtask

  initial begin
    test_reset();
    test_cpu_passthrough();
    test_basic();
    test_contention();
    test_wrap();
    test_zero_and_full();
    test_abort();
    test_reset_mid_fill();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
